// File: rtl/pbit_decode_pkg.sv
// Shared types and helpers for the p-bit sample decoder.
// Holds the FSM state type, default widths and the majority compare.
package pbit_decode_pkg;

    localparam int unsigned NBITS_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    // Widest counter the decision compare supports.
    localparam int unsigned CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } dec_state_e;

    // Majority decision: 1 iff 2*count > win, evaluated one bit wider
    // than the counters so the doubling cannot wrap. Ties decide 0.
    function automatic logic decide(
        input logic [CNT_W_MAX-1:0] count,
        input logic [CNT_W_MAX-1:0] win
    );
        logic [CNT_W_MAX:0] dbl;
        logic [CNT_W_MAX:0] lim;
        dbl = {count, 1'b0};
        lim = {1'b0, win};
        return dbl > lim;
    endfunction

endpackage

// File: rtl/pbit_bit_counter.sv
// One-bit ones counter with a registered majority decision.
// The decision is captured on the final sample of a window.
module pbit_bit_counter
    import pbit_decode_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    input  logic             last_i,
    input  logic [CNT_W-1:0] win_i,
    output logic             dec_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_q;
    logic             dec_d;

    // Count ones while enabled; on the last sample decide from the
    // count that includes this sample. Clearing leaves the decision.
    always_comb begin
        cnt_d = cnt_q;
        dec_d = dec_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(bit_i);
            if (last_i) begin
                dec_d = decide(CNT_W_MAX'(cnt_d), CNT_W_MAX'(win_i));
            end
        end
    end

    // Counter and decision registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            dec_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dec_q <= dec_d;
        end
    end

    assign dec_o = dec_q;

endmodule

// File: rtl/pbit_sample_decoder.sv
// Majority decoder for stochastic p-bit adder outputs.
// Discards a burn-in period, then votes each bit over a window.
module pbit_sample_decoder
    import pbit_decode_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window,
    input  logic [CNT_W-1:0] burn_in,
    input  logic [NBITS-1:0] a_in,
    input  logic [NBITS-1:0] b_in,
    input  logic [NBITS-1:0] s_in,
    input  logic             ovf_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] a_dec,
    output logic [NBITS-1:0] b_dec,
    output logic [NBITS-1:0] s_dec,
    output logic             ovf_dec
);

    localparam int unsigned NB = 3 * NBITS + 1;

    dec_state_e       state_q;
    dec_state_e       state_d;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] win_d;
    logic [CNT_W-1:0] burn_q;
    logic [CNT_W-1:0] burn_d;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] settle_d;
    logic [CNT_W-1:0] samp_q;
    logic [CNT_W-1:0] samp_d;

    logic [CNT_W-1:0] w_eff;
    logic             settle_done;
    logic             samp_last;
    logic             cnt_clr;
    logic             cnt_en;
    logic [NB-1:0]    smp_vec;
    logic [NB-1:0]    dec_vec;

    // A zero window still takes one sample.
    assign w_eff = (win_q == '0) ? CNT_W'(1) : win_q;

    // SETTLE is only entered with a non-zero burn-in.
    assign settle_done = (settle_q == burn_q - CNT_W'(1));
    assign samp_last   = (samp_q == w_eff - CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (burn_in == '0) begin
                            state_d = ST_ACCUM;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (samp_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Run parameters, burn-in and sample counters, bit-counter controls.
    always_comb begin
        win_d    = win_q;
        burn_d   = burn_q;
        settle_d = settle_q;
        samp_d   = samp_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        if (abort) begin
            settle_d = '0;
            samp_d   = '0;
            cnt_clr  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        win_d    = window;
                        burn_d   = burn_in;
                        settle_d = '0;
                        samp_d   = '0;
                        cnt_clr  = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    settle_d = settle_q + CNT_W'(1);
                end
                ST_ACCUM: begin
                    samp_d = samp_q + CNT_W'(1);
                    cnt_en = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Latched run parameters and progress counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q    <= '0;
            burn_q   <= '0;
            settle_q <= '0;
            samp_q   <= '0;
        end else begin
            win_q    <= win_d;
            burn_q   <= burn_d;
            settle_q <= settle_d;
            samp_q   <= samp_d;
        end
    end

    assign smp_vec = {ovf_in, s_in, b_in, a_in};

    for (genvar i = 0; i < NB; i++) begin : g_bit
        pbit_bit_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clear_i(cnt_clr),
            .en_i   (cnt_en),
            .bit_i  (smp_vec[i]),
            .last_i (samp_last),
            .win_i  (w_eff),
            .dec_o  (dec_vec[i])
        );
    end

    assign a_dec   = dec_vec[NBITS-1:0];
    assign b_dec   = dec_vec[2*NBITS-1:NBITS];
    assign s_dec   = dec_vec[3*NBITS-1:2*NBITS];
    assign ovf_dec = dec_vec[3*NBITS];

endmodule

// File: tb/tb_pbit_sample_decoder.sv
// Scoreboard bench for pbit_sample_decoder with a per-bit vote model.
// Expectations are queued at start; a monitor checks each result.
module tb_pbit_sample_decoder;

    localparam int NB = 4;
    localparam int CW = 16;

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [NB-1:0] s;
        logic          o;
        longint        cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] window = '0;
    logic [CW-1:0] burn_in = '0;
    logic [NB-1:0] a_in = '0;
    logic [NB-1:0] b_in = '0;
    logic [NB-1:0] s_in = '0;
    logic          ovf_in = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [NB-1:0] a_dec;
    logic [NB-1:0] b_dec;
    logic [NB-1:0] s_dec;
    logic          ovf_dec;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   sbq[$];

    logic [NB-1:0] ia[$];
    logic [NB-1:0] ib[$];
    logic [NB-1:0] is_[$];
    logic          io[$];

    pbit_sample_decoder #(
        .NBITS(NB),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .window   (window),
        .burn_in  (burn_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .s_in     (s_in),
        .ovf_in   (ovf_in),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_dec    (a_dec),
        .b_dec    (b_dec),
        .s_dec    (s_dec),
        .ovf_dec  (ovf_dec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fill_clear();
        ia.delete();
        ib.delete();
        is_.delete();
        io.delete();
    endtask

    task automatic add(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [NB-1:0] s, input logic o);
        ia.push_back(a);
        ib.push_back(b);
        is_.push_back(s);
        io.push_back(o);
    endtask

    // Each bit follows a per-run base value, flipped about 1/4 of the time.
    task automatic fill_rand(input int n);
        logic [NB-1:0] ba, bb, bs;
        logic          bo;
        logic [31:0]   nz;
        ba = NB'($urandom);
        bb = NB'($urandom);
        bs = NB'($urandom);
        bo = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            nz = $urandom & $urandom;
            add(ba ^ nz[3:0], bb ^ nz[7:4], bs ^ nz[11:8], bo ^ nz[12]);
        end
    endtask

    // Reference: count ones over the sampled slice, strict majority wins.
    task automatic expect_push(input int b, input int w, input longint c0);
        int            weff;
        int            ca[NB];
        int            cb[NB];
        int            cs[NB];
        int            co;
        logic [NB-1:0] va, vb, vs;
        exp_t          e;
        weff = (w == 0) ? 1 : w;
        co = 0;
        for (int i = 0; i < NB; i++) begin
            ca[i] = 0;
            cb[i] = 0;
            cs[i] = 0;
        end
        for (int j = b; j < b + weff; j++) begin
            va = ia[j];
            vb = ib[j];
            vs = is_[j];
            for (int i = 0; i < NB; i++) begin
                ca[i] += int'(va[i]);
                cb[i] += int'(vb[i]);
                cs[i] += int'(vs[i]);
            end
            co += int'(io[j]);
        end
        for (int i = 0; i < NB; i++) begin
            e.a[i] = (2 * ca[i] > weff);
            e.b[i] = (2 * cb[i] > weff);
            e.s[i] = (2 * cs[i] > weff);
        end
        e.o = (2 * co > weff);
        e.cyc = c0 + 1 + b + weff;
        sbq.push_back(e);
    endtask

    task automatic begin_run(input int b, input int w, input bit exp_done);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        window = CW'(w);
        burn_in = CW'(b);
        if (exp_done) expect_push(b, w, cyc);
    endtask

    // Drive samples; parameters and start are scrambled to show they are ignored.
    task automatic drive(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            window = CW'($urandom);
            burn_in = CW'($urandom);
            a_in = ia[k];
            b_in = ib[k];
            s_in = is_[k];
            ovf_in = io[k];
        end
    endtask

    task automatic finish_run(input int hold);
        int            t;
        logic [12:0]   snap;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!out_valid && t < 4) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            return;
        end
        snap = {a_dec, b_dec, s_dec, ovf_dec};
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (!out_valid || {a_dec, b_dec, s_dec, ovf_dec} != snap) begin
                errors++;
                $display("FAIL hold_stable: valid=%0b dec=%h required valid=1 dec=%h",
                         out_valid, {a_dec, b_dec, s_dec, ovf_dec}, snap);
            end
        end
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy || out_valid) begin
            errors++;
            $display("FAIL handshake_idle: busy=%0b valid=%0b required 0 0",
                     busy, out_valid);
        end
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic full_run(input int b, input int w, input int hold);
        begin_run(b, w, 1'b1);
        drive(b + ((w == 0) ? 1 : w));
        finish_run(hold);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                logic pv;
                pv = 1'b0;
                forever begin
                    @(negedge clk);
                    if (out_valid && !pv) begin
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_valid: out_valid=1 required 0 at cyc %0d",
                                     cyc);
                        end else begin
                            e = sbq.pop_front();
                            if ({a_dec, b_dec, s_dec, ovf_dec} != {e.a, e.b, e.s, e.o}) begin
                                errors++;
                                $display("FAIL decode: a=%h b=%h s=%h o=%0b required a=%h b=%h s=%h o=%0b",
                                         a_dec, b_dec, s_dec, ovf_dec, e.a, e.b, e.s, e.o);
                            end
                            checks++;
                            if (cyc != e.cyc) begin
                                errors++;
                                $display("FAIL latency: valid at cyc %0d required %0d",
                                         cyc, e.cyc);
                            end
                        end
                    end
                    pv = out_valid;
                end
            end
        join_none

        #1 reset = 1'b1;
        #2;
        checks++;
        if ({busy, out_valid, a_dec, b_dec, s_dec, ovf_dec} != '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b valid=%0b dec=%h required all 0",
                     busy, out_valid, {a_dec, b_dec, s_dec, ovf_dec});
        end
        @(posedge clk);
        #2 reset = 1'b0;

        // Constant words over a long window, start on first edge after reset.
        fill_clear();
        for (int k = 0; k < 1000; k++) add(4'd1, 4'd7, 4'd8, 1'b0);
        full_run(0, 1000, 2);

        // s[0] toggling: even window ties to 0, odd window starting on 1 gives 1.
        fill_clear();
        for (int k = 0; k < 100; k++) add(4'd5, 4'd10, {3'b011, (k % 2 == 0)}, 1'b1);
        full_run(0, 100, 1);
        fill_clear();
        for (int k = 0; k < 101; k++) add(4'd5, 4'd10, {3'b011, (k % 2 == 0)}, 1'b1);
        full_run(0, 101, 1);

        // Burn-in discards the leading 15s; hold with start pulses.
        fill_clear();
        for (int k = 0; k < 10; k++) add(4'd15, 4'd15, 4'd15, 1'b1);
        for (int k = 0; k < 50; k++) add(4'd3, 4'd3, 4'd3, 1'b0);
        full_run(10, 50, 5);

        // Reset in the middle of burn-in clears everything at once.
        fill_clear();
        fill_rand(30);
        begin_run(20, 10, 1'b0);
        drive(5);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, a_dec, b_dec, s_dec, ovf_dec} != '0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%0b valid=%0b dec=%h required all 0",
                     busy, out_valid, {a_dec, b_dec, s_dec, ovf_dec});
        end
        @(posedge clk);
        #2 reset = 1'b0;
        fill_clear();
        fill_rand(14);
        full_run(4, 10, 0);

        // Abort mid-accumulation, then a short fresh run.
        fill_clear();
        fill_rand(40);
        begin_run(0, 40, 1'b0);
        drive(20);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy || out_valid) begin
            errors++;
            $display("FAIL abort_idle: busy=%0b valid=%0b required 0 0", busy, out_valid);
        end
        fill_clear();
        fill_rand(8);
        full_run(0, 8, 0);

        // Abort beats start in IDLE.
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL abort_over_start: busy=%0b required 0", busy);
        end

        // Abort with a simultaneous handshake while results are shown.
        fill_clear();
        fill_rand(12);
        begin_run(2, 10, 1'b1);
        drive(12);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (busy || out_valid) begin
            errors++;
            $display("FAIL abort_in_done: busy=%0b valid=%0b required 0 0",
                     busy, out_valid);
        end

        // Zero window takes exactly one sample.
        fill_clear();
        fill_rand(4);
        full_run(3, 0, 1);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            int b;
            int w;
            b = int'($urandom_range(0, 8));
            w = int'($urandom_range(1, 60));
            fill_clear();
            fill_rand(b + w);
            full_run(b, w, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_results: pending=%0d required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
